// File: rtl/alu_result_stage.sv
// Registers adder Sum/Carry with Z/N/C/V flags in a 2-entry valid/ready FIFO; one cycle push-to-out, no bypass.
// in_ready drops while full or in reset; sticky overflow flag is built only with STICKY_FLAGS_EN.
module alu_result_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_binv,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_flags,
  input  logic             sticky_clr,
  output logic             sticky_v
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [WIDTH-1:0] r_sum   [2];
  logic [3:0]       r_flags [2];

  logic w_push;
  logic w_pop;
  logic w_bmsb;
  logic w_z;
  logic w_n;
  logic w_c;
  logic w_v;

  assign in_ready  = !rst && (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Overflow uses the effective second operand after the adder's Binv inversion.
  assign w_bmsb = in_binv ? ~in_b[WIDTH-1] : in_b[WIDTH-1];
  assign w_z    = (in_sum == '0);
  assign w_n    = in_sum[WIDTH-1];
  assign w_c    = in_carry;
  assign w_v    = (in_a[WIDTH-1] == w_bmsb) && (in_sum[WIDTH-1] != in_a[WIDTH-1]);

  assign out_sum   = r_sum[r_rd_ptr];
  assign out_flags = r_flags[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_EMPTY;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_sum[i]   <= '0;
        r_flags[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_sum[r_wr_ptr]   <= in_sum;
        r_flags[r_wr_ptr] <= {w_v, w_c, w_n, w_z};
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case (r_state)
        S_EMPTY: if (w_push) r_state <= S_ONE;
        S_ONE: begin
          if (w_push && !w_pop)      r_state <= S_FULL;
          else if (!w_push && w_pop) r_state <= S_EMPTY;
        end
        S_FULL:  if (w_pop) r_state <= S_ONE;
        default: r_state <= S_EMPTY;
      endcase
    end
  end

`ifdef STICKY_FLAGS_EN
  logic r_sticky_v;

  // A set in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (rst)                r_sticky_v <= 1'b0;
    else if (w_push && w_v) r_sticky_v <= 1'b1;
    else if (sticky_clr)    r_sticky_v <= 1'b0;
  end

  assign sticky_v = r_sticky_v;
`else
  logic w_unused_sticky_clr;

  assign w_unused_sticky_clr = sticky_clr;
  assign sticky_v            = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flags, FIFO order, backpressure, reset flush, sticky overflow.
module tb_alu_result_stage;

  localparam int WIDTH = 8;
`ifdef STICKY_FLAGS_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_binv;
  logic [WIDTH-1:0] in_sum;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [3:0]       out_flags;
  logic             sticky_clr;
  logic             sticky_v;

  int checks   = 0;
  int failures = 0;

  alu_result_stage #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_binv    (in_binv),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_flags  (out_flags),
    .sticky_clr (sticky_clr),
    .sticky_v   (sticky_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic binv, input logic [7:0] sum, input logic carry);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_binv  = binv;
    in_sum   = sum;
    in_carry = carry;
  endtask

  initial begin
    rst        = 1'b1;
    out_ready  = 1'b0;
    sticky_clr = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_sticky", sticky_v, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // 0x7F + 0x01 overflows into negative
    out_ready = 1'b1;
    drive(1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    step();
    in_valid = 1'b0;
    chk("add_ovf_valid", out_valid, 1);
    chk("add_ovf_sum", out_sum, 16'h80);
    chk("add_ovf_flags", out_flags, 4'b1010);
    step();
    chk("add_ovf_popped", out_valid, 0);

    // 5 - 5: zero result, no borrow
    drive(1'b1, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1);
    step();
    in_valid = 1'b0;
    chk("sub_eq_valid", out_valid, 1);
    chk("sub_eq_sum", out_sum, 16'h00);
    chk("sub_eq_flags", out_flags, 4'b0101);
    step();
    chk("sub_eq_popped", out_valid, 0);

    // Backpressure: third push must wait until a slot frees
    out_ready = 1'b0;
    drive(1'b1, 8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
    step();
    chk("bp_ready_after1", in_ready, 1);
    drive(1'b1, 8'h20, 8'h02, 1'b0, 8'h22, 1'b0);
    step();
    chk("bp_ready_after2", in_ready, 0);
    chk("bp_head_11", out_sum, 16'h11);
    drive(1'b1, 8'h30, 8'h03, 1'b0, 8'h33, 1'b0);
    step();
    step();
    chk("bp_full_hold_ready", in_ready, 0);
    chk("bp_full_hold_head", out_sum, 16'h11);
    out_ready = 1'b1;
    step();
    chk("bp_pop1_ready", in_ready, 1);
    chk("bp_pop1_head", out_sum, 16'h22);
    step();
    in_valid = 1'b0;
    chk("bp_pop2_valid", out_valid, 1);
    chk("bp_pop2_head", out_sum, 16'h33);
    chk("bp_pop2_flags", out_flags, 4'b0000);
    step();
    chk("bp_drained", out_valid, 0);

    // Steady push+pop at one entry
    out_ready = 1'b0;
    drive(1'b1, 8'h40, 8'h00, 1'b0, 8'h40, 1'b0);
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'h40 + 8'(i), 8'h00, 1'b0, 8'h40 + 8'(i), 1'b0);
      chk("pp_valid", out_valid, 1);
      chk("pp_ready", in_ready, 1);
      chk("pp_head", out_sum, 16'(8'h40 + 8'(i - 1)));
      step();
    end
    in_valid = 1'b0;
    chk("pp_last_head", out_sum, 16'h48);
    step();
    chk("pp_drained", out_valid, 0);

    // Reset while full with a push pending
    out_ready = 1'b0;
    drive(1'b1, 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1);
    step();
    drive(1'b1, 8'h60, 8'h06, 1'b0, 8'h66, 1'b0);
    step();
    chk("rstmid_full", in_ready, 0);
    chk("rstmid_head_sum", out_sum, 16'h7F);
    chk("rstmid_head_flags", out_flags, 4'b1100);
    rst = 1'b1;
    drive(1'b1, 8'h70, 8'h07, 1'b0, 8'h77, 1'b0);
    step();
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_sum", out_sum, 0);
    chk("rstmid_flags", out_flags, 0);
    chk("rstmid_in_ready", in_ready, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    chk("rstmid_lost", out_valid, 0);
    chk("rstmid_ready_back", in_ready, 1);

    // Sticky overflow
    out_ready = 1'b1;
    drive(1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    step();
    chk("sticky_set", sticky_v, STICKY);
    drive(1'b1, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1);
    step();
    chk("sticky_hold", sticky_v, STICKY);
    sticky_clr = 1'b1;
    drive(1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    step();
    chk("sticky_set_wins", sticky_v, STICKY);
    in_valid = 1'b0;
    step();
    sticky_clr = 1'b0;
    chk("sticky_cleared", sticky_v, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
